pcm_capture: RTL and testbench
==============================

PCM_CAPTURE -- requirements
Module: pcm_capture

Interface
REQ-001 SHALL have port clk, input, 1, single clock for all logic.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset: asserted (0) forces reset immediately, released synchronously to clk.
REQ-003 SHALL have port next_sample, input, 1, base-rate tick, one clk wide.
REQ-004 SHALL have port sample_rate, input, 8, rate increment; values above 128 are treated as 128.
REQ-005 SHALL have ports mode_stereo and mode_16bit, input, 1 each, capture format.
REQ-006 SHALL have port enable, input, 1, capture enable.
REQ-007 SHALL have ports left_in and right_in, input, 16 each, signed two's-complement ADC samples.
REQ-008 SHALL have port fifo_reset, input, 1, synchronous FIFO flush.
REQ-009 SHALL have ports fifo_read (input, 1), fifo_rddata (output, 8), fifo_empty (output, 1), fifo_almost_full (output, 1), overflow (output, 1) forming the host read interface.

Function
REQ-010 SHALL keep an 8-bit accumulator that adds the clamped sample_rate on each next_sample tick.
REQ-011 SHALL raise an internal new_sample strobe one clk after a tick where accumulator bit 7 changed; sample_rate 0 SHALL never raise it.
REQ-012 SHALL hold a 64-entry x 8-bit FIFO with a 7-bit occupancy count.
REQ-013 SHALL drive fifo_empty = (count == 0) and fifo_almost_full = (count >= 48).
REQ-014 SHALL register fifo_rddata so it is valid the clk after fifo_read; fifo_read while empty SHALL be ignored with rddata unchanged.
REQ-015 SHALL allow a simultaneous read and write in one clk, leaving count unchanged.
REQ-016 SHALL start a frame on new_sample when enable=1 and state is IDLE, latching left_in, right_in, mode_stereo and mode_16bit. Mode changes mid-frame SHALL take effect at the next frame only.
REQ-017 SHALL size frames as (stereo ? 2 : 1) x (16bit ? 2 : 1) bytes.
REQ-018 SHALL commit a frame only if free space >= frame size at its start. Otherwise it SHALL drop the whole frame, write no bytes, and set overflow.
REQ-019 SHALL form the mono sample as (left_in + right_in) >>> 1, using a 17-bit signed sum with the result truncated to 16 bits.
REQ-020 SHALL use these states: IDLE, PUSH_L_LO, PUSH_L_HI, PUSH_R_LO, PUSH_R_HI.
 - Each push state writes one byte per clk.
 - 16-bit byte order: low byte then high byte, left before right.
 - 8-bit mode: only the high byte [15:8] of each channel is written, using the _HI states and skipping the _LO states.
 - After the last byte, the state returns to IDLE.
REQ-021 SHALL give the first byte a latency of 1 clk after new_sample and finish a 4-byte frame 4 clk after new_sample.
REQ-022 SHALL set overflow when new_sample arrives while not IDLE; that sample SHALL be ignored.
REQ-023 SHALL do nothing on new_sample when enable=0. Deasserting enable mid-frame SHALL let the current frame complete.
REQ-024 SHALL, on fifo_reset=1:
 - empty the FIFO (count 0);
 - abort any frame and return to IDLE;
 - clear overflow;
 - leave the accumulator unchanged.
 fifo_reset SHALL take priority over a same-clk read, write or new_sample.
REQ-025 SHALL keep overflow sticky until fifo_reset or rst.

Reset
REQ-026 SHALL, on rst=0, set the accumulator to 0, the delayed strobe to 0, state to IDLE, FIFO count and pointers to 0, fifo_rddata to 0x00, overflow to 0, fifo_empty to 1, and fifo_almost_full to 0.
REQ-027 SHALL, when rst is asserted mid-frame, discard any partially written frame; the host SHALL see an empty FIFO.

Verification
REQ-028 SHALL cover this scenario: 16-bit stereo, L=0x1234, R=0xABCD, sample_rate=128, one tick -> bytes 34,12,CD,AB read in order; count 4 one clk after the 4th push.
REQ-029 SHALL cover this scenario: 8-bit mono, L=0x7F00, R=0x0100 -> one byte 0x40; L=0x8000, R=0x8000 -> byte 0x80.
REQ-030 SHALL cover this scenario: FIFO at count 62, 16-bit stereo frame due -> nothing written, count stays 62, overflow=1. A later 8-bit mono frame SHALL be written, giving count 63.
REQ-031 SHALL cover this scenario: sample_rate=64 with continuous ticks -> new_sample every 2nd tick. sample_rate=200 SHALL behave identically to 128.
REQ-032 SHALL cover this scenario: fifo_reset in the same clk as fifo_read and PUSH_L_HI -> count 0, state IDLE, overflow 0, no byte written.
REQ-033 SHALL cover this scenario: rst pulsed low mid-frame, asynchronous to clk -> all outputs reach their reset values (REQ-026) immediately, and capture resumes on the first tick after release.

Source files
------------

// File: rtl/pcm_capture.sv
// PCM capture front end: a rate accumulator produces sample strobes, and an FSM packs
// latched ADC samples as bytes into a 64-byte FIFO that the host drains one byte at a time.
module pcm_capture (
  input  logic        clk,
  input  logic        rst,
  input  logic        next_sample,
  input  logic [7:0]  sample_rate,
  input  logic        mode_stereo,
  input  logic        mode_16bit,
  input  logic        enable,
  input  logic [15:0] left_in,
  input  logic [15:0] right_in,
  input  logic        fifo_reset,
  input  logic        fifo_read,
  output logic [7:0]  fifo_rddata,
  output logic        fifo_empty,
  output logic        fifo_almost_full,
  output logic        overflow
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PUSH_L_LO = 3'd1,
    PUSH_L_HI = 3'd2,
    PUSH_R_LO = 3'd3,
    PUSH_R_HI = 3'd4
  } state_t;

  function automatic logic [7:0] clamp_rate(input logic [7:0] rate);
    return (rate > 8'd128) ? 8'd128 : rate;
  endfunction

  // 17-bit signed sum, arithmetic shift by one, keep the low 16 bits.
  function automatic logic [15:0] mono_mix(input logic [15:0] l, input logic [15:0] r);
    logic [16:0] sum;
    sum = {l[15], l} + {r[15], r};
    return sum[16:1];
  endfunction

  function automatic logic [2:0] frame_bytes(input logic stereo, input logic b16);
    logic [2:0] n;
    case ({stereo, b16})
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      2'b10:   n = 3'd2;
      2'b11:   n = 3'd4;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  logic [7:0]  acc_r;
  logic [7:0]  acc_sum_s;
  logic        new_sample_r;
  state_t      state_r;
  state_t      next_push_s;
  logic [15:0] left_r;
  logic [15:0] right_r;
  logic        stereo_r;
  logic        b16_r;
  logic        overflow_r;
  logic [7:0]  mem_r [0:63];
  logic [5:0]  wr_ptr_r;
  logic [5:0]  rd_ptr_r;
  logic [6:0]  count_r;
  logic [6:0]  count_next_s;
  logic [6:0]  free_s;
  logic        start_ok_s;
  logic        wr_en_s;
  logic        rd_en_s;
  logic [7:0]  wr_data_s;
  logic [7:0]  rddata_r;
  logic        empty_r;
  logic        afull_r;

  assign acc_sum_s = acc_r + clamp_rate(sample_rate);

  // Rate accumulator; the strobe fires the clk after a tick that toggles bit 7.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r        <= 8'd0;
      new_sample_r <= 1'b0;
    end else if (next_sample) begin
      acc_r        <= acc_sum_s;
      new_sample_r <= acc_sum_s[7] ^ acc_r[7];
    end else begin
      new_sample_r <= 1'b0;
    end
  end

  // Push datapath: byte to write and the state that follows each push state.
  always_comb begin
    wr_en_s     = 1'b0;
    wr_data_s   = 8'd0;
    next_push_s = IDLE;
    case (state_r)
      PUSH_L_LO: begin
        wr_en_s     = 1'b1;
        wr_data_s   = left_r[7:0];
        next_push_s = PUSH_L_HI;
      end
      PUSH_L_HI: begin
        wr_en_s     = 1'b1;
        wr_data_s   = left_r[15:8];
        next_push_s = stereo_r ? (b16_r ? PUSH_R_LO : PUSH_R_HI) : IDLE;
      end
      PUSH_R_LO: begin
        wr_en_s     = 1'b1;
        wr_data_s   = right_r[7:0];
        next_push_s = PUSH_R_HI;
      end
      PUSH_R_HI: begin
        wr_en_s     = 1'b1;
        wr_data_s   = right_r[15:8];
        next_push_s = IDLE;
      end
      default: begin
        wr_en_s     = 1'b0;
        wr_data_s   = 8'd0;
        next_push_s = IDLE;
      end
    endcase
    if (fifo_reset) begin
      wr_en_s = 1'b0;
    end else begin
      wr_en_s = wr_en_s;
    end
  end

  // Space is reserved for the whole frame at its start, so pushes never hit a full FIFO.
  assign free_s       = 7'd64 - count_r;
  assign start_ok_s   = ({4'd0, frame_bytes(mode_stereo, mode_16bit)} <= free_s);
  assign rd_en_s      = fifo_read && (count_r != 7'd0) && !fifo_reset;
  assign count_next_s = count_r + {6'd0, wr_en_s} - {6'd0, rd_en_s};

  // Frame FSM: start, drop or abort frames and keep the sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      left_r     <= 16'd0;
      right_r    <= 16'd0;
      stereo_r   <= 1'b0;
      b16_r      <= 1'b0;
      overflow_r <= 1'b0;
    end else if (fifo_reset) begin
      state_r    <= IDLE;
      overflow_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (new_sample_r && enable && start_ok_s) begin
            left_r   <= mode_stereo ? left_in : mono_mix(left_in, right_in);
            right_r  <= right_in;
            stereo_r <= mode_stereo;
            b16_r    <= mode_16bit;
            state_r  <= mode_16bit ? PUSH_L_LO : PUSH_L_HI;
          end
        end
        default: state_r <= next_push_s;
      endcase
      if (new_sample_r && enable && ((state_r != IDLE) || !start_ok_s)) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // FIFO storage has no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= wr_data_s;
    end
  end

  // FIFO pointers, occupancy and registered host-side outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= 6'd0;
      rd_ptr_r <= 6'd0;
      count_r  <= 7'd0;
      rddata_r <= 8'd0;
      empty_r  <= 1'b1;
      afull_r  <= 1'b0;
    end else if (fifo_reset) begin
      wr_ptr_r <= 6'd0;
      rd_ptr_r <= 6'd0;
      count_r  <= 7'd0;
      empty_r  <= 1'b1;
      afull_r  <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + 6'd1;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + 6'd1;
        rddata_r <= mem_r[rd_ptr_r];
      end
      count_r <= count_next_s;
      empty_r <= (count_next_s == 7'd0);
      afull_r <= (count_next_s >= 7'd48);
    end
  end

  assign fifo_rddata      = rddata_r;
  assign fifo_empty       = empty_r;
  assign fifo_almost_full = afull_r;
  assign overflow         = overflow_r;

endmodule

// File: tb/tb_pcm_capture.sv
// Self-checking bench for pcm_capture: constant vector table, directed corner sequences,
// and random frames checked against a byte-queue model of the FIFO contents.
module tb_pcm_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        next_sample = 1'b0;
  logic [7:0]  sample_rate = 8'd128;
  logic        mode_stereo = 1'b0;
  logic        mode_16bit = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] left_in = 16'h0000;
  logic [15:0] right_in = 16'h0000;
  logic        fifo_reset = 1'b0;
  logic        fifo_read = 1'b0;
  logic [7:0]  fifo_rddata;
  logic        fifo_empty;
  logic        fifo_almost_full;
  logic        overflow;

  pcm_capture dut (
    .clk(clk), .rst(rst), .next_sample(next_sample), .sample_rate(sample_rate),
    .mode_stereo(mode_stereo), .mode_16bit(mode_16bit), .enable(enable),
    .left_in(left_in), .right_in(right_in), .fifo_reset(fifo_reset),
    .fifo_read(fifo_read), .fifo_rddata(fifo_rddata), .fifo_empty(fifo_empty),
    .fifo_almost_full(fifo_almost_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] q[$];
  logic       exp_ovf = 1'b0;
  logic [7:0] last_exp = 8'h00;

  typedef struct {
    logic        st;
    logic        b16;
    logic [15:0] l;
    logic [15:0] r;
    int          n;
    logic [31:0] bytes;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: bytes a frame contributes, all-or-nothing against 64 bytes of capacity.
  task automatic expect_frame(input logic st, input logic b16, input logic [15:0] l, input logic [15:0] r);
    logic [15:0] ch[$];
    logic [7:0]  bytes[$];
    int          m;
    if (st) begin
      ch.push_back(l);
      ch.push_back(r);
    end else begin
      m = ($signed(l) + $signed(r)) >>> 1;
      ch.push_back(m[15:0]);
    end
    foreach (ch[i]) begin
      if (b16) bytes.push_back(ch[i][7:0]);
      bytes.push_back(ch[i][15:8]);
    end
    if (q.size() + bytes.size() > 64) exp_ovf = 1'b1;
    else foreach (bytes[i]) q.push_back(bytes[i]);
  endtask

  task automatic tick();
    next_sample = 1'b1;
    step();
    next_sample = 1'b0;
  endtask

  task automatic set_frame(input logic st, input logic b16, input logic [15:0] l, input logic [15:0] r);
    mode_stereo = st;
    mode_16bit  = b16;
    left_in     = l;
    right_in    = r;
  endtask

  task automatic capture(input logic st, input logic b16, input logic [15:0] l, input logic [15:0] r);
    set_frame(st, b16, l, r);
    tick();
    expect_frame(st, b16, l, r);
    repeat (6) step();
  endtask

  task automatic read_byte(output logic [7:0] b);
    fifo_read = 1'b1;
    step();
    fifo_read = 1'b0;
    b = fifo_rddata;
  endtask

  task automatic fifo_clear();
    fifo_reset = 1'b1;
    step();
    fifo_reset = 1'b0;
    q.delete();
    exp_ovf = 1'b0;
  endtask

  task automatic drain(input string name);
    logic [7:0] b;
    check({name, "_afull"}, fifo_almost_full, q.size() >= 48);
    check({name, "_ovf"}, overflow, exp_ovf);
    while (q.size() > 0) begin
      check({name, "_notempty"}, fifo_empty, 1'b0);
      read_byte(b);
      last_exp = q.pop_front();
      check({name, "_byte"}, b, last_exp);
    end
    check({name, "_empty"}, fifo_empty, 1'b1);
  endtask

  initial begin
    logic [7:0] b;
    vecs[0] = '{1'b1, 1'b1, 16'h1234, 16'hABCD, 4, 32'hABCD1234};
    vecs[1] = '{1'b0, 1'b0, 16'h7F00, 16'h0100, 1, 32'h00000040};
    vecs[2] = '{1'b0, 1'b0, 16'h8000, 16'h8000, 1, 32'h00000080};
    vecs[3] = '{1'b0, 1'b1, 16'h0002, 16'h0004, 2, 32'h00000003};
    vecs[4] = '{1'b1, 1'b0, 16'h1234, 16'hABCD, 2, 32'h0000AB12};
    vecs[5] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 2, 32'h0000FFFF};
    vecs[6] = '{1'b0, 1'b1, 16'h7FFF, 16'h7FFF, 2, 32'h00007FFF};

    #2 rst = 1'b0;
    step();
    check("rst_rddata", fifo_rddata, 8'h00);
    check("rst_empty", fifo_empty, 1'b1);
    check("rst_afull", fifo_almost_full, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    rst = 1'b1;
    step();

    // Constant vector table.
    for (int i = 0; i < 7; i++) begin
      fifo_clear();
      capture(vecs[i].st, vecs[i].b16, vecs[i].l, vecs[i].r);
      for (int j = 0; j < vecs[i].n; j++) begin
        read_byte(b);
        check($sformatf("vec%0d_b%0d", i, j), b, vecs[i].bytes[j*8 +: 8]);
      end
      check($sformatf("vec%0d_empty", i), fifo_empty, 1'b1);
    end
    fifo_clear();

    // Read while empty leaves rddata unchanged.
    capture(1'b0, 1'b0, 16'h5A00, 16'h5A00);
    drain("last");
    read_byte(b);
    check("rd_empty_hold", b, last_exp);
    check("rd_empty_flag", fifo_empty, 1'b1);

    // First-byte latency and new_sample while busy.
    fifo_clear();
    set_frame(1'b1, 1'b1, 16'hA1A2, 16'hB1B2);
    tick();
    step();
    check("lat_empty1", fifo_empty, 1'b1);
    step();
    check("lat_empty0", fifo_empty, 1'b0);
    step();
    tick();
    step();
    expect_frame(1'b1, 1'b1, 16'hA1A2, 16'hB1B2);
    exp_ovf = 1'b1;
    check("busy_ovf", overflow, 1'b1);
    repeat (4) step();
    drain("busy");
    fifo_clear();
    check("clr_ovf", overflow, 1'b0);
    tick();
    repeat (4) step();
    tick();
    expect_frame(1'b1, 1'b1, 16'hA1A2, 16'hB1B2);
    expect_frame(1'b1, 1'b1, 16'hA1A2, 16'hB1B2);
    repeat (6) step();
    drain("b2b");

    // Enable gating and mid-frame enable drop.
    fifo_clear();
    enable = 1'b0;
    set_frame(1'b1, 1'b1, 16'h0F0E, 16'h0D0C);
    tick();
    repeat (6) step();
    check("en0_empty", fifo_empty, 1'b1);
    enable = 1'b1;
    tick();
    step();
    enable = 1'b0;
    expect_frame(1'b1, 1'b1, 16'h0F0E, 16'h0D0C);
    repeat (6) step();
    drain("en_drop");
    enable = 1'b1;

    // Count 62 then an oversize frame is dropped; a 1-byte frame still fits.
    fifo_clear();
    for (int i = 0; i < 15; i++) capture(1'b1, 1'b1, 16'(i * 16'h0101), 16'(16'hF000 + i));
    capture(1'b1, 1'b0, 16'h3300, 16'h4400);
    check("fill_ovf0", overflow, 1'b0);
    capture(1'b1, 1'b1, 16'hDEAD, 16'hBEEF);
    check("fill_ovf1", overflow, 1'b1);
    capture(1'b0, 1'b0, 16'h2000, 16'h6000);
    drain("fill");

    // Rate accumulator: 64 every 2nd tick, 200 clamps to 128, 0 never.
    fifo_clear();
    set_frame(1'b0, 1'b0, 16'h4000, 16'h4000);
    sample_rate = 8'd64;
    for (int i = 0; i < 8; i++) begin tick(); repeat (5) step(); end
    repeat (4) expect_frame(1'b0, 1'b0, 16'h4000, 16'h4000);
    drain("rate64");
    sample_rate = 8'd200;
    for (int i = 0; i < 6; i++) begin tick(); repeat (5) step(); end
    repeat (6) expect_frame(1'b0, 1'b0, 16'h4000, 16'h4000);
    drain("rate200");
    sample_rate = 8'd0;
    for (int i = 0; i < 4; i++) begin tick(); repeat (5) step(); end
    drain("rate0");
    sample_rate = 8'd128;

    // fifo_reset together with a read and PUSH_L_HI.
    fifo_clear();
    set_frame(1'b1, 1'b1, 16'h1357, 16'h2468);
    tick();
    step();
    tick();
    expect_frame(1'b1, 1'b1, 16'h1357, 16'h2468);
    repeat (6) step();
    check("fr_pre_ovf", overflow, 1'b1);
    check("fr_pre_empty", fifo_empty, 1'b0);
    tick();
    step();
    step();
    fifo_reset = 1'b1;
    fifo_read = 1'b1;
    step();
    fifo_reset = 1'b0;
    fifo_read = 1'b0;
    q.delete();
    exp_ovf = 1'b0;
    check("fr_ovf", overflow, 1'b0);
    check("fr_empty", fifo_empty, 1'b1);
    repeat (6) step();
    check("fr_no_write", fifo_empty, 1'b1);
    capture(1'b1, 1'b1, 16'hCAFE, 16'hF00D);
    drain("fr_after");

    // Asynchronous reset mid-frame with a non-trivial FIFO state.
    fifo_clear();
    for (int i = 0; i < 13; i++) capture(1'b1, 1'b1, 16'h1111, 16'(16'h2222 + i));
    read_byte(b);
    check("ar_pre_rd", b, q.pop_front());
    tick();
    step();
    tick();
    step();
    check("ar_pre_ovf", overflow, 1'b1);
    check("ar_pre_afull", fifo_almost_full, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("ar_empty", fifo_empty, 1'b1);
    check("ar_afull", fifo_almost_full, 1'b0);
    check("ar_ovf", overflow, 1'b0);
    check("ar_rddata", fifo_rddata, 8'h00);
    step();
    rst = 1'b1;
    q.delete();
    exp_ovf = 1'b0;
    repeat (6) step();
    check("ar_no_partial", fifo_empty, 1'b1);
    capture(1'b1, 1'b1, 16'h0A0B, 16'h0C0D);
    drain("ar_resume");

    // Random frames and interleaved reads against the queue model.
    fifo_clear();
    for (int i = 0; i < 60; i++) begin
      capture(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
      check("rnd_ovf", overflow, exp_ovf);
      if ($urandom_range(0, 2) == 0) begin
        for (int j = 0; j < 3 && q.size() > 0; j++) begin
          read_byte(b);
          check("rnd_byte", b, q.pop_front());
        end
      end
    end
    drain("rnd_final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
